// File: rtl/uart_fifo_ctrl.sv
// Full-duplex UART with TX/RX FIFOs, stop-bit checking and sticky error flags.
// Optional parity (even by default, PARITY_ODD selects odd) is enabled by UART_PARITY_EN.
module uart_fifo_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int FIFO_DEPTH = 4
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 uart_clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_write,
  output logic                 tx_full,
  output logic                 tx_idle,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_read,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic                 err_clear
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  // ---------------- transmit side ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [PW-1:0]        tx_wr, tx_rd;
  logic [CW-1:0]        tx_cnt;
  logic                 tx_push, tx_pop;
  tx_state_t            tx_state;
  logic [TW-1:0]        tx_timer;
  logic [BW-1:0]        tx_bitc;
  logic [DATA_BITS-1:0] tx_shift;

  assign tx_full = (tx_cnt == DEPTH);
  assign tx_idle = (tx_state == TX_IDLE) && (tx_cnt == '0);
  // A frame is loaded from IDLE or straight out of the last stop-bit cycle.
  assign tx_pop  = (tx_cnt != '0) &&
                   ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_timer == T_LAST));
  assign tx_push = tx_write && (!tx_full || tx_pop);

  always_ff @(posedge uart_clk) begin
    if (tx_push) tx_mem[tx_wr] <= tx_data;
  end

  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_bitc  <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_timer <= '0;
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rd];
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          tx_timer <= tx_timer + TW'(1);
          if (tx_timer == T_LAST) begin
            tx_timer <= '0;
            tx_bitc  <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          tx_timer <= tx_timer + TW'(1);
          if (tx_timer == T_LAST) begin
            tx_timer <= '0;
            if (tx_bitc == B_LAST) begin
`ifdef UART_PARITY_EN
              uart_tx  <= (^tx_shift) ^ PARITY_ODD;
              tx_state <= TX_PARITY;
`else
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_bitc <= tx_bitc + BW'(1);
              uart_tx <= tx_shift[tx_bitc + BW'(1)];
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          tx_timer <= tx_timer + TW'(1);
          if (tx_timer == T_LAST) begin
            tx_timer <= '0;
            uart_tx  <= 1'b1;
            tx_state <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          tx_timer <= tx_timer + TW'(1);
          if (tx_timer == T_LAST) begin
            tx_timer <= '0;
            if (tx_pop) begin
              tx_shift <= tx_mem[tx_rd];
              uart_tx  <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receive side ----------------
  logic                 rx_s1, rx_s2;
  rx_state_t            rx_state;
  logic [TW-1:0]        rx_timer;
  logic [BW-1:0]        rx_bitc;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]        rx_wr, rx_rd;
  logic [CW-1:0]        rx_cnt;
  logic                 rx_done, rx_push, rx_pop, rx_accept, ovr_set, fe_set;

  assign rx_done   = (rx_state == RX_STOP) && (rx_timer == T_LAST);
  assign rx_push   = rx_done && rx_s2;
  assign fe_set    = rx_done && !rx_s2;
  assign rx_valid  = (rx_cnt != '0);
  assign rx_pop    = rx_read && rx_valid;
  assign rx_accept = rx_push && ((rx_cnt != DEPTH) || rx_pop);
  assign ovr_set   = rx_push && !rx_accept;
  assign rx_data   = rx_mem[rx_rd];

  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  // In IDLE the bit timer doubles as the consecutive-low counter.
  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_timer <= '0;
      rx_bitc  <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_s2) begin
            rx_timer <= '0;
          end else if (rx_timer == T_HALF) begin
            rx_timer <= '0;
            rx_bitc  <= '0;
            rx_state <= RX_DATA;
          end else begin
            rx_timer <= rx_timer + TW'(1);
          end
        end
        RX_DATA: begin
          rx_timer <= rx_timer + TW'(1);
          if (rx_timer == T_LAST) begin
            rx_timer <= '0;
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            rx_bitc  <= rx_bitc + BW'(1);
`ifdef UART_PARITY_EN
            if (rx_bitc == B_LAST) rx_state <= RX_PARITY;
`else
            if (rx_bitc == B_LAST) rx_state <= RX_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          rx_timer <= rx_timer + TW'(1);
          if (rx_timer == T_LAST) begin
            rx_timer <= '0;
            rx_state <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          rx_timer <= rx_timer + TW'(1);
          if (rx_timer == T_LAST) begin
            rx_timer <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          rx_timer <= '0;
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
      rx_wr        <= '0;
      rx_rd        <= '0;
      rx_cnt       <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_accept) begin
        rx_mem[rx_wr] <= rx_shift;
        rx_wr         <= rx_wr + PW'(1);
      end
      if (rx_pop) rx_rd <= rx_rd + PW'(1);
      rx_cnt       <= rx_cnt + CW'(rx_accept) - CW'(rx_pop);
      rx_overrun   <= ovr_set | (rx_overrun & ~err_clear);
      rx_frame_err <= fe_set | (rx_frame_err & ~err_clear);
    end
  end

`ifdef UART_PARITY_EN
  logic pe_set;
  assign pe_set = (rx_state == RX_PARITY) && (rx_timer == T_LAST) &&
                  (rx_s2 != ((^rx_shift) ^ PARITY_ODD));

  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) rx_parity_err <= 1'b0;
    else       rx_parity_err <= pe_set | (rx_parity_err & ~err_clear);
  end
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: a queue/timestamp model of both directions
// is compared against the DUT after every clock edge, plus literal spot checks.
module tb_uart_fifo_ctrl;

  localparam int DB    = 8;
  localparam int OS    = 8;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int NP   = 1;
  localparam bit PODD = 1'b0;
`else
  localparam int NP   = 0;
  localparam bit PODD = 1'b0;
`endif
  localparam int FRAME  = (DB + NP + 2) * OS;
  // Edge of the stop-bit sample relative to the edge where the start bit is first driven
  localparam int RX_LAT = 1 + OS / 2 + (DB + NP + 1) * OS;
  localparam int EV_GOOD = 0, EV_BAD = 1, EV_PAR = 2;

  logic          uart_clk, reset, uart_rx, uart_tx;
  logic [DB-1:0] tx_data, rx_data;
  logic          tx_write, tx_full, tx_idle, rx_valid, rx_read;
  logic          rx_overrun, rx_frame_err, rx_parity_err, err_clear;

  uart_fifo_ctrl #(
    .DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
`ifdef UART_PARITY_EN
    , .PARITY_ODD(PODD)
`endif
  ) dut (
    .uart_clk(uart_clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full), .tx_idle(tx_idle),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .err_clear(err_clear)
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  int checks = 0;
  int fails  = 0;
  longint n;

  typedef struct { longint at; int kind; logic [DB-1:0] word; } ev_t;
  logic [DB-1:0] txq[$];
  logic [DB-1:0] rxq[$];
  ev_t           evq[$];
  bit            linq[$];
  longint        tx_start, tx_end;
  logic [DB-1:0] tx_cur;
  bit            m_ovr, m_fe, m_pe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  function automatic bit frame_bit(input logic [DB-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= DB) return w[k-1];
    if (NP == 1 && k == DB + 1) return (^w) ^ PODD;
    return 1'b1;
  endfunction

  task automatic model_reset();
    txq.delete(); rxq.delete(); evq.delete(); linq.delete();
    n = 0; tx_end = 0; tx_start = -FRAME; tx_cur = '0;
    m_ovr = 0; m_fe = 0; m_pe = 0;
  endtask

  task automatic model_edge(input bit w, input logic [DB-1:0] d, input bit rd, input bit clr);
    bit s_ovr = 0, s_fe = 0, s_pe = 0;
    ev_t ev;
    if (txq.size() > 0 && n >= tx_end) begin
      tx_cur = txq.pop_front(); tx_start = n; tx_end = n + FRAME;
    end
    if (w && txq.size() < DEPTH) txq.push_back(d);
    if (rd && rxq.size() > 0) void'(rxq.pop_front());
    if (evq.size() > 0 && evq[0].at == n) begin
      ev = evq.pop_front();
      case (ev.kind)
        EV_GOOD: if (rxq.size() < DEPTH) rxq.push_back(ev.word); else s_ovr = 1;
        EV_BAD:  s_fe = 1;
        default: s_pe = 1;
      endcase
    end
    m_ovr = s_ovr | (m_ovr & ~clr);
    m_fe  = s_fe  | (m_fe  & ~clr);
    m_pe  = s_pe  | (m_pe  & ~clr);
  endtask

  task automatic compare();
    bit exp_tx = (n < tx_end) ? frame_bit(tx_cur, int'((n - tx_start) / OS)) : 1'b1;
    check("uart_tx", uart_tx, exp_tx);
    check("tx_full", tx_full, txq.size() == DEPTH);
    check("tx_idle", tx_idle, txq.size() == 0 && n >= tx_end);
    check("rx_valid", rx_valid, rxq.size() > 0);
    if (rxq.size() > 0) check("rx_data", rx_data, rxq[0]);
    check("rx_overrun", rx_overrun, m_ovr);
    check("rx_frame_err", rx_frame_err, m_fe);
    check("rx_parity_err", rx_parity_err, m_pe);
  endtask

  // Called at a falling edge; drives inputs, advances one rising edge, checks, returns at next falling edge.
  task automatic step(input bit w, input logic [DB-1:0] d, input bit rd, input bit clr);
    tx_write = w; tx_data = d; rx_read = rd; err_clear = clr;
    uart_rx = (linq.size() > 0) ? linq.pop_front() : 1'b1;
    @(posedge uart_clk);
    model_edge(w, d, rd, clr);
    #1 compare();
    n++;
    @(negedge uart_clk);
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic add_frame(input logic [DB-1:0] w, input bit stop_ok, input bit par_bad,
                           input int gap, input int extra_low);
    longint t = n + linq.size() + gap;
    bit b;
    repeat (gap) linq.push_back(1'b1);
    for (int k = 0; k <= DB + NP; k++) begin
      b = frame_bit(w, k);
      if (NP == 1 && k == DB + 1 && par_bad) b = ~b;
      repeat (OS) linq.push_back(b);
    end
    repeat (OS + (stop_ok ? 0 : extra_low)) linq.push_back(stop_ok);
    if (!stop_ok) repeat (3) linq.push_back(1'b1);
    if (par_bad) evq.push_back('{t + RX_LAT - OS, EV_PAR, w});
    evq.push_back('{t + RX_LAT, stop_ok ? EV_GOOD : EV_BAD, w});
  endtask

  task automatic check_reset_values();
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_tx_full", tx_full, 1'b0);
    check("rst_tx_idle", tx_idle, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 0);
    check("rst_flags", {rx_overrun, rx_frame_err, rx_parity_err}, 0);
  endtask

  initial begin
    logic [9:0] a5_pat = 10'b1101001010;
    longint t, e;
    int guard, wr_pct, rd_pct;

    reset = 1'b1; uart_rx = 1'b1; tx_write = 1'b0; tx_data = '0;
    rx_read = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge uart_clk);
    reset = 1'b0;
    model_reset();
    check_reset_values();

    // Single 0xA5 frame: start falls one edge after the write, idle 80 edges after the fall
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int j = 1; j <= 81; j++) begin
      idle_step();
`ifndef UART_PARITY_EN
      if (j <= 80) check("a5_bit", uart_tx, a5_pat[(j-1)/8]);
      if (j == 80) check("a5_idle_early", tx_idle, 1'b0);
      if (j == 81) check("a5_idle", tx_idle, 1'b1);
`endif
    end

    // Six writes into a 4-deep FIFO: fifth fills it, sixth is dropped
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, DB'(i), 1'b0, 1'b0);
      if (i == 4) check("burst_not_full", tx_full, 1'b0);
      if (i == 5) check("burst_full", tx_full, 1'b1);
    end
    guard = 0;
    while (!tx_idle && guard < 1000) begin idle_step(); guard++; end
    check("burst_drain_timeout", guard < 1000, 1'b1);

    // Clean 0x3C frame
    t = n + linq.size();
    add_frame(8'h3C, 1'b1, 1'b0, 0, 0);
    guard = 0;
    while (!rx_valid && guard < 200) begin idle_step(); guard++; end
    e = n - 1;
    check("rx3c_timeout", guard < 200, 1'b1);
`ifndef UART_PARITY_EN
    check("rx3c_latency", 32'(e - t), 77);
`endif
    check("rx3c_data", rx_data, 8'h3C);
    check("rx3c_flags", {rx_overrun, rx_frame_err, rx_parity_err}, 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("rx3c_popped", rx_valid, 1'b0);

    // Bad stop on 0x55 with a long low line, then 0x12
    add_frame(8'h55, 1'b0, 1'b0, 0, 30);
    add_frame(8'h12, 1'b1, 1'b0, 2, 0);
    guard = 0;
    while (!rx_valid && guard < 400) begin idle_step(); guard++; end
    check("bad_stop_timeout", guard < 400, 1'b1);
    check("bad_stop_fe", rx_frame_err, 1'b1);
    check("bad_stop_next", rx_data, 8'h12);
    step(1'b0, '0, 1'b1, 1'b1);
    check("err_cleared", rx_frame_err, 1'b0);

    // Five frames without reading: fifth overruns
    for (int i = 0; i < 5; i++) add_frame(DB'(8'h10 + i), 1'b1, 1'b0, 1, 0);
    repeat (5 * FRAME + 20) idle_step();
    check("ovr_flag", rx_overrun, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("ovr_order", rx_data, 8'h10 + i);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovr_cleared", rx_overrun, 1'b0);

    // Three-cycle glitch is rejected
    repeat (3) linq.push_back(1'b0);
    repeat (100) idle_step();
    check("glitch_ignored", rx_valid, 1'b0);

`ifdef UART_PARITY_EN
    add_frame(8'h07, 1'b1, 1'b1, 0, 0);
    repeat (FRAME + 10) idle_step();
    check("par_err", rx_parity_err, 1'b1);
    check("par_data", rx_data, 8'h07);
    step(1'b0, '0, 1'b1, 1'b1);
`endif

    // Randomised traffic on both directions
    wr_pct = 30; rd_pct = 10;
    for (int c = 0; c < 8000; c++) begin
      if (c % 1000 == 0) begin
        wr_pct = $urandom_range(0, 60);
        case ($urandom_range(0, 2))
          0: rd_pct = 0;
          1: rd_pct = 10;
          default: rd_pct = 80;
        endcase
      end
      if (linq.size() == 0) begin
        case ($urandom_range(0, 19))
          0: begin
            repeat ($urandom_range(1, OS/2 - 1)) linq.push_back(1'b0);
            repeat (2) linq.push_back(1'b1);
          end
          1: add_frame(DB'($urandom), 1'b0, 1'b0, $urandom_range(0, 5), $urandom_range(0, 30));
          default: add_frame(DB'($urandom), 1'b1, (NP == 1) && ($urandom_range(0, 4) == 0),
                             $urandom_range(0, 10), 0);
        endcase
      end
      step($urandom_range(0, 99) < wr_pct, DB'($urandom),
           $urandom_range(0, 99) < rd_pct, $urandom_range(0, 199) == 0);
    end

    // Reset during a start bit forces the line high without waiting for a clock
    step(1'b1, 8'h33, 1'b0, 1'b0);
    idle_step();
    idle_step();
    reset = 1'b1;
    #1 check("async_reset_tx", uart_tx, 1'b1);
    uart_rx = 1'b1;
    repeat (2) @(negedge uart_clk);
    reset = 1'b0;
    model_reset();
    check_reset_values();
    repeat (20) idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
